neureka_streamout_scheduler: RTL and testbench

Sequences the streamout phase of the NEUREKA engine's per-PE accumulators. It latches a per-job PE enable mask and arms the enabled accumulators for streamout. It then walks the enabled PEs in ascending index order, driving the serializer select, `enable_accumulator` and `last_pe` controls while counting store beats. It sits in the engine controller, between the job FSM and the engine's `ctrl_engine_t` streamout fields.

---
 rtl/neureka_streamout_scheduler.sv | 146 ++++++++++++++
 tb/tb_neureka_streamout_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/neureka_streamout_scheduler.sv
// Streamout sequencer for the NEUREKA per-PE accumulators: arms the masked PEs, then walks them
// in ascending order counting store beats. Optional stall counter under NEUREKA_STREAMOUT_SCHED_PERF_EN.
module neureka_streamout_scheduler #(
  parameter int NR_PE     = 16,
  parameter int MAX_BEATS = 4,
  parameter int SEL_W     = $clog2(NR_PE),
  parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [NR_PE-1:0]  pe_mask_i,
  input  logic [BEAT_W-1:0] nb_beats_i,
  input  logic              out_valid_i,
  input  logic              out_ready_i,
  output logic              goto_streamout_o,
  output logic [NR_PE-1:0]  enable_accumulator_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [NR_PE-1:0]  sel_onehot_o,
  output logic              last_pe_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       perf_stall_o,
  output logic [1:0]        dbg_state_o
);

  // Store handshake: out_valid_i/out_ready_i are only observed; one beat is transferred
  // in every STREAM cycle where both are high. Neither signal reaches an output combinationally.

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [NR_PE-1:0]  rem_q, rem_d, en_q, en_d, low_bit, rem_after;
  logic [BEAT_W-1:0] nb_q, nb_d, cnt_q, cnt_d, nb_clamp;
  logic [SEL_W-1:0]  sel;
  logic              hs;

  always_comb begin
    nb_clamp = nb_beats_i;
    if (nb_beats_i == '0) nb_clamp = BEAT_W'(1);
    else if (nb_beats_i > BEAT_W'(MAX_BEATS)) nb_clamp = BEAT_W'(MAX_BEATS);
  end

  // The serialized PE is always the lowest bit still pending in the remaining mask.
  assign low_bit   = rem_q & (~rem_q + NR_PE'(1));
  assign rem_after = rem_q & ~low_bit;

  always_comb begin
    sel = '0;
    for (int i = NR_PE - 1; i >= 0; i--) begin
      if (rem_q[i]) sel = SEL_W'(i);
    end
  end

  assign hs = (state_q == STREAM) & out_valid_i & out_ready_i;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    en_d    = en_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = IDLE;
      rem_d   = '0;
      en_d    = '0;
      nb_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (pe_mask_i != '0) begin
              en_d    = pe_mask_i;
              rem_d   = pe_mask_i;
              nb_d    = nb_clamp;
              cnt_d   = '0;
              state_d = ARM;
            end else begin
              state_d = DONE;
            end
          end
        end
        ARM:    state_d = STREAM;
        STREAM: begin
          if (hs) begin
            if (cnt_q == nb_q - BEAT_W'(1)) begin
              rem_d = rem_after;
              cnt_d = '0;
              if (rem_after == '0) state_d = DONE;
            end else begin
              cnt_d = cnt_q + BEAT_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      en_q    <= '0;
      nb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign goto_streamout_o     = (state_q == ARM);
  assign enable_accumulator_o = en_q;
  assign sel_o                = sel;
  assign sel_onehot_o         = (state_q == STREAM) ? (NR_PE'(1) << sel) : '0;
  assign last_pe_o            = (state_q == STREAM) & (rem_q != '0) & (rem_after == '0);
  assign busy_o               = (state_q != IDLE);
  assign done_o               = (state_q == DONE);
  assign dbg_state_o          = state_q;

`ifdef NEUREKA_STREAMOUT_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (clear_i || (state_q == IDLE && start_i)) begin
      perf_q <= '0;
    end else if (state_q == STREAM && out_valid_i && !out_ready_i && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_neureka_streamout_scheduler.sv
// Scoreboard bench for neureka_streamout_scheduler: a job-level model queues expected beats,
// arm pulses and completions; a negedge monitor pops and compares them.
module tb_neureka_streamout_scheduler;

  logic        clk = 1'b0;
  logic        rst, clear, start, out_valid, out_ready;
  logic [15:0] pe_mask;
  logic [2:0]  nb_beats;
  logic        goto_streamout, last_pe, busy, done;
  logic [15:0] enable_accumulator, sel_onehot;
  logic [3:0]  sel;
  logic [31:0] perf_stall;
  logic [1:0]  dbg_state;

  neureka_streamout_scheduler dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .pe_mask_i(pe_mask), .nb_beats_i(nb_beats),
    .out_valid_i(out_valid), .out_ready_i(out_ready),
    .goto_streamout_o(goto_streamout), .enable_accumulator_o(enable_accumulator),
    .sel_o(sel), .sel_onehot_o(sel_onehot), .last_pe_o(last_pe),
    .busy_o(busy), .done_o(done), .perf_stall_o(perf_stall), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0]  exp_beats[$];   // {pe index, last_pe}
  logic [15:0] exp_goto[$];    // enable mask seen during ARM
  logic [47:0] exp_done[$];    // {enable mask, stall count}
  logic [15:0] en_model = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready && sel_onehot != '0) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          logic [4:0] e;
          e = exp_beats.pop_front();
          chk("beat_sel", sel, e[4:1]);
          chk("beat_last", last_pe, e[0]);
          chk("beat_onehot", sel_onehot, 16'(1) << e[4:1]);
        end
      end
      if (busy && sel_onehot == '0) chk("last_outside_stream", last_pe, 0);
      if (goto_streamout) begin
        if (exp_goto.size() == 0) chk("unexpected_goto", 1, 0);
        else chk("goto_enable", enable_accumulator, exp_goto.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_enable_perf", {enable_accumulator, perf_stall}, exp_done.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_push(input logic [15:0] mask, input logic [2:0] nb,
                            output int total, output int first);
    int eff, last;
    eff   = (nb == 0) ? 1 : ((nb > 4) ? 4 : int'(nb));
    total = 0;
    last  = -1;
    first = 0;
    for (int i = 15; i >= 0; i--) if (mask[i]) first = i;
    for (int i = 0; i < 16; i++) if (mask[i]) begin last = i; total += eff; end
    for (int i = 0; i < 16; i++)
      if (mask[i]) for (int b = 0; b < eff; b++) exp_beats.push_back({4'(i), i == last});
    if (mask != 0) begin
      en_model = mask;
      exp_goto.push_back(mask);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] mask, input logic [2:0] nb);
    step();
    start = 1'b1; pe_mask = mask; nb_beats = nb;
    out_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    step();
    start = 1'b0; pe_mask = 16'($urandom); nb_beats = 3'($urandom);
  endtask

  // mode 0: valid/ready always high; 1: random; 2: ready low for stream cycles 1..3
  task automatic run_job(input logic [15:0] mask, input logic [2:0] nb, input int mode);
    int total, first, hs_n, stalls, cyc;
    logic v, r;
    model_push(mask, nb, total, first);
    pulse_start(mask, nb);
    if (mask == 0) begin
      exp_done.push_back({en_model, 32'd0});
      chk("zero_mask_done", done, 1);
      chk("zero_mask_goto", goto_streamout, 0);
      step();
      chk("zero_mask_idle", {busy, done}, 0);
      return;
    end
    chk("arm_busy", busy, 1);
    chk("arm_sel", sel, 4'(first));
    out_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    step();
    hs_n = 0; stalls = 0; cyc = 0;
    while (hs_n < total && cyc < 3000) begin
      case (mode)
        0:       begin v = 1'b1; r = 1'b1; end
        2:       begin v = 1'b1; r = !(cyc >= 1 && cyc <= 3); end
        default: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0); end
      endcase
      out_valid = v; out_ready = r;
      if (v && r) hs_n++;
      if (v && !r) stalls++;
      cyc++;
      step();
    end
    if (cyc >= 3000) chk("stream_timeout", 1, 0);
`ifdef NEUREKA_STREAMOUT_SCHED_PERF_EN
    exp_done.push_back({en_model, 32'(stalls)});
`else
    exp_done.push_back({en_model, 32'd0});
`endif
    out_valid = 1'b0; out_ready = 1'b0;
    chk("done_on_time", {done, busy}, 2'b11);
    chk("beats_consumed", exp_beats.size(), 0);
    step();
    chk("idle_after_done", {done, busy, goto_streamout}, 0);
    chk("enable_held", enable_accumulator, en_model);
    chk("sel_idle", sel, 0);
  endtask

  task automatic flush_model();
    exp_beats.delete();
    exp_goto.delete();
    exp_done.delete();
    en_model = '0;
  endtask

  task automatic check_zeroed(input string name);
    chk(name, {busy, done, goto_streamout, last_pe, sel, sel_onehot, enable_accumulator, dbg_state}, 0);
    chk({name, "_perf"}, perf_stall, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int total, first;
    rst = 1'b1; clear = 1'b0; start = 1'b0; out_valid = 1'b0; out_ready = 1'b0;
    pe_mask = '0; nb_beats = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zeroed("reset_outputs");
    rst = 1'b0;
    step();
    check_zeroed("post_reset_outputs");

    run_job(16'hFFFF, 3'd4, 0);
    run_job(16'h8421, 3'd1, 0);
    run_job(16'h0000, 3'd2, 0);
    run_job(16'h0C30, 3'd0, 0);
    run_job(16'h0C30, 3'd7, 0);
    run_job(16'h0006, 3'd4, 2);

    // clear in the middle of PE 2 while start is also held high
    model_push(16'hFFFF, 3'd2, total, first);
    pulse_start(16'hFFFF, 3'd2);
    start = 1'b1; out_valid = 1'b1; out_ready = 1'b1;
    step();
    repeat (5) step();
    chk("pre_clear_sel", sel, 2);
    clear = 1'b1; out_valid = 1'b0; out_ready = 1'b0;
    step();
    clear = 1'b1; start = 1'b1;
    check_zeroed("after_clear");
    flush_model();
    step();
    clear = 1'b0; start = 1'b0;
    check_zeroed("clear_beats_start");
    repeat (3) step();
    chk("no_done_after_clear", {done, busy}, 0);
    run_job(16'h1248, 3'd3, 0);

    // asynchronous reset mid-job
    model_push(16'hF0F0, 3'd3, total, first);
    pulse_start(16'hF0F0, 3'd3);
    out_valid = 1'b1; out_ready = 1'b1;
    repeat (4) step();
    #2 rst = 1'b1;
    #1 check_zeroed("async_reset");
    flush_model();
    out_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    run_job(16'h0101, 3'd2, 0);

    for (int j = 0; j < 14; j++) begin
      logic [15:0] m;
      m = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      run_job(m, 3'($urandom_range(0, 7)), 1);
    end

    repeat (2) step();
    chk("queues_empty", exp_beats.size() + exp_goto.size() + exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
